// File: rtl/bus_port_arbiter.sv
// Shares one slave port among N_PORTS masters. The winner of arbitration owns
// the slave for a complete single, INCR or WRAP transaction.
module bus_port_arbiter #(
  parameter int N_PORTS   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int ARB_MODE  = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PORTS*ADDR_W-1:0]     M_ADDR,
  input  logic [N_PORTS*DATA_W-1:0]     M_WDATA,
  input  logic [N_PORTS*(DATA_W/8)-1:0] M_BSTROBE,
  input  logic [N_PORTS*2-1:0]          M_BURST,
  input  logic [N_PORTS-1:0]            M_REQ,
  input  logic [N_PORTS-1:0]            M_WRB,
  output logic [DATA_W-1:0]             M_RDATA,
  output logic [N_PORTS-1:0]            M_ACK,
  output logic [N_PORTS-1:0]            M_STALL,
  output logic [ADDR_W-1:0]             S_ADDR,
  output logic [1:0]                    S_BURST,
  output logic                          S_REQ,
  output logic                          S_WRB,
  output logic [DATA_W-1:0]             S_WDATA,
  output logic [DATA_W/8-1:0]           S_BSTROBE,
  input  logic [DATA_W-1:0]             S_RDATA,
  input  logic                          S_ACK,
  input  logic                          S_STALL,
  output logic [N_PORTS-1:0]            GRANT
);
  localparam int SW = DATA_W / 8;
  localparam int OW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam logic [OW-1:0] LAST_IDX    = OW'(N_PORTS - 1);
  localparam logic [CW-1:0] BURST_BEATS = CW'(BURST_LEN);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state, state_nx;
  logic [N_PORTS-1:0]  grant_nx;
  logic [OW-1:0]       owner, owner_nx, last_owner, last_owner_nx;
  logic [OW-1:0]       start, win_idx;
  logic                win_found;
  logic [CW-1:0]       beat_cnt, beat_cnt_nx, beats_need;
  logic [1:0]          burst, burst_nx;

  logic [ADDR_W-1:0]   addr_a   [N_PORTS];
  logic [DATA_W-1:0]   wdata_a  [N_PORTS];
  logic [SW-1:0]       strobe_a [N_PORTS];
  logic [1:0]          burst_a  [N_PORTS];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_unpack
    assign addr_a[i]   = M_ADDR[i*ADDR_W +: ADDR_W];
    assign wdata_a[i]  = M_WDATA[i*DATA_W +: DATA_W];
    assign strobe_a[i] = M_BSTROBE[i*SW +: SW];
    assign burst_a[i]  = M_BURST[i*2 +: 2];
  end

  // Returns {found, index}; lowest search offset from start wins.
  function automatic logic [OW:0] pick_winner(input logic [N_PORTS-1:0] req,
                                               input logic [OW-1:0] first);
    logic [OW:0]   res;
    logic [OW-1:0] idx;
    res = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx = (ARB_MODE == 1) ? OW'((int'(first) + k) % N_PORTS) : OW'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign start = (last_owner == LAST_IDX) ? '0 : last_owner + OW'(1);
  assign {win_found, win_idx} = pick_winner(M_REQ, start);

  always_comb begin
    case (burst)
      2'b01, 2'b10: beats_need = BURST_BEATS;
      default:      beats_need = CW'(1);
    endcase
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = GRANT;
    owner_nx      = owner;
    last_owner_nx = last_owner;
    beat_cnt_nx   = beat_cnt;
    burst_nx      = burst;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nx      = BUSY;
          grant_nx      = N_PORTS'(1) << win_idx;
          owner_nx      = win_idx;
          last_owner_nx = win_idx;
          beat_cnt_nx   = '0;
          burst_nx      = burst_a[win_idx];
        end else begin
          grant_nx = '0;
        end
      end
      BUSY: begin
        // A beat counts on every slave ack, stalled or not.
        if (S_ACK) begin
          if (beat_cnt + CW'(1) >= beats_need) begin
            state_nx    = IDLE;
            grant_nx    = '0;
            beat_cnt_nx = '0;
          end else begin
            beat_cnt_nx = beat_cnt + CW'(1);
          end
        end else if (!M_REQ[owner] && beat_cnt == '0) begin
          state_nx = IDLE;
          grant_nx = '0;
        end else begin
          state_nx = BUSY;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      GRANT      <= '0;
      owner      <= '0;
      last_owner <= LAST_IDX;
      beat_cnt   <= '0;
      burst      <= 2'b00;
    end else begin
      state      <= state_nx;
      GRANT      <= grant_nx;
      owner      <= owner_nx;
      last_owner <= last_owner_nx;
      beat_cnt   <= beat_cnt_nx;
      burst      <= burst_nx;
    end
  end

  // Owner's request path is a live mux; everyone else is held off.
  always_comb begin
    S_ADDR    = '0;
    S_WDATA   = '0;
    S_BSTROBE = '0;
    S_BURST   = 2'b00;
    S_WRB     = 1'b0;
    S_REQ     = 1'b0;
    M_ACK     = '0;
    M_STALL   = '1;
    M_RDATA   = '0;
    if (state == BUSY) begin
      S_ADDR         = addr_a[owner];
      S_WDATA        = wdata_a[owner];
      S_BSTROBE      = strobe_a[owner];
      S_BURST        = burst_a[owner];
      S_WRB          = M_WRB[owner];
      S_REQ          = M_REQ[owner];
      M_ACK[owner]   = S_ACK;
      M_STALL[owner] = S_STALL;
      M_RDATA        = S_RDATA;
    end else begin
      S_REQ = 1'b0;
    end
  end
endmodule
